// File: rtl/stc_pkg.sv
// Shared definitions for the STC attenuator path: FSM state type, word size,
// and counter-width helper.
package stc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } att_state_t;

    localparam int ATT_W = 7;
    localparam logic [ATT_W-1:0] ATT_MAX = 7'h7F;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/att_bit_timer.sv
// SCLK phase timer: counts CLK_DIV cycles per half-period, toggles the sclk level
// at each phase end and flags the phase end. Held cleared while disabled.
module att_bit_timer
    import stc_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic phase_end,
    output logic sclk
);

    localparam int CW = cnt_w(CLK_DIV);

    logic [CW-1:0] cnt;

    assign phase_end = en && (cnt == CW'(CLK_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (phase_end) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/att_serial_wr.sv
// Serial writer for a digital step attenuator: sends d_in whenever it differs
// from the last word sent. Define ATT_LSB_FIRST_EN to shift bit 0 first.
module att_serial_wr
    import stc_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int LE_W    = 2,
    parameter int W       = ATT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_in,
    output logic         sclk,
    output logic         sdata,
    output logic         le,
    output logic         busy,
    output logic         done,
    output logic [15:0]  wr_count
);

    localparam int BW = cnt_w(W);
    localparam int LW = cnt_w(LE_W);

    att_state_t    state, state_nxt;
    logic [W-1:0]  shreg, shreg_shifted, last_sent;
    logic          init_pend;
    logic [BW-1:0] bit_cnt;
    logic [LW-1:0] le_cnt, le_cnt_nxt;
    logic          phase_end, start, bit_end, last_bit, le_last;
    logic          busy_nxt, le_nxt, done_nxt;

    att_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .en        (state == ST_SHIFT),
        .phase_end (phase_end),
        .sclk      (sclk)
    );

    assign start    = (state == ST_IDLE) && (init_pend || (d_in != last_sent));
    assign bit_end  = phase_end && sclk;
    assign last_bit = (bit_cnt == BW'(W - 1));
    assign le_last  = (le_cnt == LW'(LE_W - 1));

    // Zero fill drains the register, so sdata is already 0 when LATCH begins.
`ifdef ATT_LSB_FIRST_EN
    assign sdata         = shreg[0];
    assign shreg_shifted = {1'b0, shreg[W-1:1]};
`else
    assign sdata         = shreg[W-1];
    assign shreg_shifted = {shreg[W-2:0], 1'b0};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            le_cnt <= '0;
            busy   <= 1'b0;
            le     <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            le_cnt <= le_cnt_nxt;
            busy   <= busy_nxt;
            le     <= le_nxt;
            done   <= done_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start)              state_nxt = ST_SHIFT;
            ST_SHIFT: if (bit_end && last_bit) state_nxt = ST_LATCH;
            ST_LATCH: if (le_last)            state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead and registered above.
    always_comb begin
        le_cnt_nxt = '0;
        if (state_nxt == ST_LATCH && state == ST_LATCH)
            le_cnt_nxt = le_cnt + 1'b1;
        busy_nxt = (state_nxt != ST_IDLE);
        le_nxt   = (state_nxt == ST_LATCH);
        done_nxt = le_nxt && (le_cnt_nxt == LW'(LE_W - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            last_sent <= '1;
            init_pend <= 1'b1;
            bit_cnt   <= '0;
            wr_count  <= '0;
        end else begin
            if (start) begin
                shreg     <= d_in;
                last_sent <= d_in;
                init_pend <= 1'b0;
                bit_cnt   <= '0;
            end else if (state == ST_SHIFT && bit_end) begin
                shreg   <= shreg_shifted;
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            end
            if (done_nxt)
                wr_count <= wr_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_att_serial_wr.sv
// Self-checking bench for att_serial_wr: directed scenarios plus random d_in
// and reset traffic, compared cycle by cycle against a transfer-level model.
module tb_att_serial_wr;

    localparam int CLK_DIV = 2;
    localparam int LE_W    = 2;
    localparam int W       = 7;
    localparam int SH      = 2 * CLK_DIV * W;
    localparam int TLEN    = SH + LE_W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] d_in = 7'h7F;
    logic         sclk, sdata, le, busy, done;
    logic [15:0]  wr_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    att_serial_wr #(.CLK_DIV(CLK_DIV), .LE_W(LE_W), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .d_in     (d_in),
        .sclk     (sclk),
        .sdata    (sdata),
        .le       (le),
        .busy     (busy),
        .done     (done),
        .wr_count (wr_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transfer-level model: remaining busy cycles of the current transfer.
    int           busy_left = 0;
    logic [W-1:0] m_last    = '1;
    logic [W-1:0] m_cur     = '0;
    bit           m_pend    = 1'b1;
    logic [15:0]  m_count   = '0;

    // Observed serial stream.
    logic         prev_sclk = 1'b0;
    logic [W-1:0] seq       = '0;
    int           nbits     = 0;
    int           run       = 0;
    logic [W-1:0] log_q[$];

    function automatic int bit_index(input int i);
`ifdef ATT_LSB_FIRST_EN
        return i;
`else
        return W - 1 - i;
`endif
    endfunction

    // Order in which the word's bits appear on the wire, first bit in the MSB.
    function automatic logic [W-1:0] exp_seq(input logic [W-1:0] w);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[W-1-i] = w[bit_index(i)];
        return r;
    endfunction

    function automatic void model_step();
        if (rst) begin
            busy_left = 0;
            m_last    = '1;
            m_pend    = 1'b1;
            m_count   = '0;
        end else if (busy_left == 0) begin
            if (m_pend || d_in != m_last) begin
                m_cur     = d_in;
                m_last    = d_in;
                m_pend    = 1'b0;
                busy_left = TLEN;
            end
        end else begin
            busy_left--;
            if (busy_left == 1) m_count++;
        end
    endfunction

    task automatic compare();
        int   pos;
        logic e_sclk, e_sdata, e_le, e_done, e_busy;
        e_sclk = 0; e_sdata = 0; e_le = 0; e_done = 0;
        e_busy = (busy_left > 0);
        if (e_busy) begin
            pos = TLEN - busy_left;
            if (pos < SH) begin
                e_sclk  = (pos % (2 * CLK_DIV)) >= CLK_DIV;
                e_sdata = m_cur[bit_index(pos / (2 * CLK_DIV))];
            end else begin
                e_le   = 1'b1;
                e_done = (pos == TLEN - 1);
            end
        end
        check("sclk", 32'(sclk), 32'(e_sclk));
        check("sdata", 32'(sdata), 32'(e_sdata));
        check("le", 32'(le), 32'(e_le));
        check("busy", 32'(busy), 32'(e_busy));
        check("done", 32'(done), 32'(e_done));
        check("wr_count", 32'(wr_count), 32'(m_count));
        check("le_and_sclk", 32'(le & sclk), 32'd0);
        if (rst) begin
            nbits = 0; run = 0; prev_sclk = 1'b0;
        end else begin
            if (sclk && !prev_sclk) begin
                seq = {seq[W-2:0], sdata};
                nbits++;
            end
            prev_sclk = sclk;
            if (busy) run++;
            else if (run > 0) begin
                check("busy_len", 32'(run), 32'(TLEN));
                run = 0;
            end
            if (e_done) begin
                check("nbits", 32'(nbits), 32'(W));
                check("word", 32'(seq), 32'(exp_seq(m_cur)));
                log_q.push_back(seq);
                nbits = 0;
            end
        end
    endtask

    task automatic cycle(input logic [W-1:0] d, input logic r);
        d_in = d;
        rst  = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic run_cycles(input logic [W-1:0] d, input int n);
        for (int i = 0; i < n; i++) cycle(d, 1'b0);
    endtask

    initial begin
        int hits;
        logic [W-1:0] v;

        // Reset, then release with the maximum code held: exactly one transfer.
        for (int i = 0; i < 3; i++) cycle(7'h7F, 1'b1);
        log_q.delete();
        run_cycles(7'h7F, 80);
        check("init_count", 32'(wr_count), 32'd1);
        check("init_nlog", 32'(log_q.size()), 32'd1);

        // Single change to 0x56.
        log_q.delete();
        run_cycles(7'h56, 40);
        check("x56_nlog", 32'(log_q.size()), 32'd1);
`ifdef ATT_LSB_FIRST_EN
        if (log_q.size() > 0) check("x56_seq", 32'(log_q[0]), 32'(7'b0110101));
`else
        if (log_q.size() > 0) check("x56_seq", 32'(log_q[0]), 32'(7'b1010110));
`endif
        check("x56_count", 32'(wr_count), 32'd2);

        // Changes during a transfer: only the latest value is sent next.
        log_q.delete();
        run_cycles(7'h4C, 5);
        run_cycles(7'h43, 5);
        run_cycles(7'h3B, 70);
        check("drop_nlog", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            check("drop_first", 32'(log_q[0]), 32'(exp_seq(7'h4C)));
            check("drop_second", 32'(log_q[1]), 32'(exp_seq(7'h3B)));
        end
        hits = 0;
        foreach (log_q[i]) if (log_q[i] == exp_seq(7'h43)) hits++;
        check("drop_x43_absent", 32'(hits), 32'd0);

        // Reset during bit 3 of 0x2E: immediate abort, then full resend.
        log_q.delete();
        run_cycles(7'h2E, 14);
        rst = 1'b1;
        #1;
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_sdata", 32'(sdata), 32'd0);
        check("abort_le", 32'(le), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        cycle(7'h2E, 1'b1);
        cycle(7'h2E, 1'b1);
        run_cycles(7'h2E, 40);
        check("abort_count", 32'(wr_count), 32'd1);
        check("abort_nlog", 32'(log_q.size()), 32'd1);
        if (log_q.size() > 0) check("abort_word", 32'(log_q[0]), 32'(exp_seq(7'h2E)));

        // Bit-order check with 0x0B.
        log_q.delete();
        run_cycles(7'h0B, 40);
        check("x0b_nlog", 32'(log_q.size()), 32'd1);
`ifdef ATT_LSB_FIRST_EN
        if (log_q.size() > 0) check("x0b_seq", 32'(log_q[0]), 32'(7'b1101000));
`else
        if (log_q.size() > 0) check("x0b_seq", 32'(log_q[0]), 32'(7'b0001011));
`endif

        // Random traffic with occasional repeats and resets.
        v = 7'h0B;
        for (int it = 0; it < 250; it++) begin
            int hold;
            if ($urandom_range(0, 3) != 0) v = W'($urandom);
            hold = $urandom_range(1, 45);
            for (int c = 0; c < hold; c++) begin
                if ($urandom_range(0, 399) == 0) cycle(v, 1'b1);
                else cycle(v, 1'b0);
            end
        end
        run_cycles(v, 2 * TLEN + 4);
        check("final_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/att_serial_wr.md
ATT_SERIAL_WR -- requirements
Module: att_serial_wr

Interface
REQ-001 Parameter CLK_DIV, default 2, SCLK half-period in clk cycles (legal ≥1).
REQ-002 Parameter LE_W, default 2, latch-enable pulse width in clk cycles (legal ≥1).
REQ-003 Parameter W, default 7, attenuator word width in bits.
REQ-004 clk  input  1  system clock, all logic on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 d_in  input  W  attenuation code from the STC generator, sampled every clk.
REQ-007 sclk  output  1  serial clock to the digital step attenuator.
REQ-008 sdata  output  1  serial data to the attenuator.
REQ-009 le  output  1  attenuator latch enable, active-high.
REQ-010 busy  output  1  high while a transfer is in SHIFT or LATCH.
REQ-011 done  output  1  one-cycle pulse on the final LATCH cycle.
REQ-012 wr_count  output  16  number of completed transfers, wraps at 2^16.

Function
REQ-013 States: IDLE, SHIFT, LATCH; any other encoding SHALL return to IDLE next cycle.
REQ-014 IDLE: if init_pend=1 or d_in≠last_sent, SHALL load d_in into shift register and last_sent, clear init_pend, and enter SHIFT on the next edge.
REQ-015 SHIFT: each of W bits SHALL occupy 2·CLK_DIV cycles: sclk=0 for CLK_DIV cycles, then sclk=1 for CLK_DIV cycles; sdata constant for the whole bit.
REQ-016 Default bit order SHALL be MSB first (bit W-1 first).
REQ-017 After the last bit's high phase, SHALL enter LATCH with sclk=0, sdata=0.
REQ-018 LATCH: le=1 for exactly LE_W cycles; done=1 on the last; wr_count increments on the same edge; then IDLE.
REQ-019 Latency: d_in change seen in IDLE at cycle n → busy=1 and first bit on sdata at n+1 → first sclk rise at n+1+CLK_DIV.
REQ-020 Transfer length: busy high for exactly 2·CLK_DIV·W + LE_W cycles.
REQ-021 d_in changes during SHIFT/LATCH SHALL NOT alter the transfer in progress; on return to IDLE the current d_in is compared again (latest value wins, intermediate values dropped).
REQ-022 Back-to-back: a pending difference SHALL start the next transfer one cycle after LATCH ends (one IDLE cycle minimum).
REQ-023 le and sclk SHALL never be high simultaneously.
REQ-024 All outputs SHALL be registered (no combinational paths from d_in).
REQ-025 Counters SHALL be sized ceil(log2) of their terminal value, min 1 bit.

Reset
REQ-026 On rst: state IDLE, sclk=0, sdata=0, le=0, busy=0, done=0, wr_count=0, last_sent=all-ones, init_pend=1.
REQ-027 rst asserted mid-transfer SHALL abort immediately with no le pulse; after release the current d_in is sent unconditionally (init_pend).

Configuration
REQ-028 Macro ATT_LSB_FIRST_EN: defined → bits shifted LSB first (bit 0 first); undefined → MSB first; timing identical in both.

Structure
REQ-029 Shared package stc_pkg SHALL hold the state typedef, ATT_W=7, and ATT_MAX=7'h7F (maximum attenuation code).
REQ-030 One sub-module att_bit_timer (CLK_DIV phase counter, emits phase-end strobe and sclk level) is natural; all else in att_serial_wr.

Verification (CLK_DIV=2, LE_W=2, W=7, transfer = 30 busy cycles)
REQ-031 Release reset with d_in=7'h7F held → one transfer of 1111111, le high 2 cycles, wr_count=1, no further transfer.
REQ-032 d_in 7'h7F→7'h56 → sdata sequence 1010110 sampled on 7 sclk rises, first rise 3 cycles after change, done pulse, wr_count+1.
REQ-033 d_in steps 7'h4C, 7'h43, 7'h3B at cycles 5, 10 of a transfer → only 7'h4C then 7'h3B sent; 7'h43 never appears.
REQ-034 rst pulse at bit 3 of a transfer of 7'h2E → outputs zero immediately, no le; after release 7'h2E resent in full, wr_count=1.
REQ-035 With ATT_LSB_FIRST_EN, d_in=7'h0B → sdata sequence 1101000; without, 0001011.
REQ-036 Throughout all scenarios: assert le∧sclk never true and busy width = 30 cycles.
